// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state type and default width for the multi-cycle ALU.
package alu_pkg;
    localparam int WIDTH_DEF = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;
    localparam logic [3:0] OP_ADC  = 4'd7;
    localparam logic [3:0] OP_SBC  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/alu_mul.sv
// Shift-add unsigned multiplier, one partial product per cycle.
// done is high during the final cycle; product then holds the finished value for the parent to register.
module alu_mul #(
    parameter int WIDTH = alu_pkg::WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_comb begin
        product = acc + (mplier[0] ? mcand : '0);
        done    = (cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts, shift-add multiply.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             CY,
    output logic             Z,
    output logic             N,
    output logic             OV
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    state_e             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   sh;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      sh_cnt;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   r1;
    logic               c1, v1, is_shift;
    logic [WIDTH-1:0]   sh_nx;
    logic               sh_bit;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    assign busy     = (state == RUN);
    assign is_shift = (op == OP_SHL) || (op == OP_SHR);
    assign sh_cnt   = (32'(b) >= WIDTH) ? CW'(WIDTH) : CW'(b);
    assign sh_nx    = (op_q == OP_SHL) ? (sh << 1) : (sh >> 1);
    assign sh_bit   = (op_q == OP_SHL) ? sh[MSB] : sh[0];

    alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .rst(rst),
        .start(start && state == IDLE && op == OP_MUL),
        .a(a), .b(b), .done(mul_done), .product(product)
    );

    // Single-cycle result; a zero-count shift lands here as a pass-through of a.
    always_comb begin
        sum = '0;
        r1  = '0;
        c1  = 1'b0;
        v1  = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin && op == OP_ADC};
                r1  = sum[MSB:0];
                c1  = sum[WIDTH];
                v1  = (a[MSB] == b[MSB]) && (r1[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin && op == OP_SBC};
                r1  = sum[MSB:0];
                c1  = sum[WIDTH];
                v1  = (a[MSB] != b[MSB]) && (r1[MSB] != a[MSB]);
            end
            OP_AND:         r1 = a & b;
            OP_OR:          r1 = a | b;
            OP_XOR:         r1 = a ^ b;
            OP_NOT:         r1 = ~a;
            OP_SHL, OP_SHR: r1 = a;
            default:        r1 = b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            sh     <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            out    <= '0;
            out_hi <= '0;
            CY     <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
            OV     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    if (op == OP_MUL) begin
                        state <= RUN;
                    end else if (is_shift && sh_cnt != '0) begin
                        state <= RUN;
                        sh    <= a;
                        cnt   <= sh_cnt;
                    end else begin
                        done   <= 1'b1;
                        out    <= r1;
                        out_hi <= '0;
                        CY     <= c1;
                        Z      <= (r1 == '0);
                        N      <= r1[MSB];
                        OV     <= v1;
                    end
                end
                RUN: if (op_q == OP_MUL) begin
                    if (mul_done) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        out    <= product[MSB:0];
                        out_hi <= product[2*WIDTH-1:WIDTH];
                        CY     <= (product[2*WIDTH-1:WIDTH] != '0);
                        Z      <= (product == '0);
                        N      <= product[2*WIDTH-1];
                        OV     <= 1'b0;
                    end
                end else begin
                    sh  <= sh_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        out    <= sh_nx;
                        out_hi <= '0;
                        CY     <= sh_bit;
                        Z      <= (sh_nx == '0);
                        N      <= sh_nx[MSB];
                        OV     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed plus random stimulus for alu_mc with a scoreboard of model-predicted results.
module tb_alu_mc;
    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, CY, Z, N, OV;
    logic [W-1:0] out, out_hi;

    typedef struct {int out, hi, cy, z, n, ov, lat;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0, last_out = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .out(out), .out_hi(out_hi),
        .CY(CY), .Z(Z), .N(N), .OV(OV)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sg(int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic exp_t model(int o, int x, int y, int ci);
        exp_t e;
        int s, c, sv, k;
        e = '{default: 0};
        c = (y > W) ? W : y;
        k = (o == 7 || o == 8) ? ci : 0;
        s = 0;
        case (o)
            0, 7: begin
                s = x + y + k; e.out = s & 255; e.cy = (s >> 8) & 1;
                sv = sg(x) + sg(y) + k; e.ov = (sv > 127 || sv < -128) ? 1 : 0;
            end
            1, 8: begin
                s = x - y - k; e.out = s & 255; e.cy = (x < y + k) ? 1 : 0;
                sv = sg(x) - sg(y) - k; e.ov = (sv > 127 || sv < -128) ? 1 : 0;
            end
            2: e.out = x & y;
            3: e.out = x | y;
            4: e.out = x ^ y;
            5: e.out = (~x) & 255;
            9: begin
                e.out = (x << c) & 255; e.cy = (c == 0) ? 0 : (x >> (W - c)) & 1; e.lat = c;
            end
            10: begin
                e.out = x >> c; e.cy = (c == 0) ? 0 : (x >> (c - 1)) & 1; e.lat = c;
            end
            11: begin
                s = x * y; e.out = s & 255; e.hi = s >> 8; e.cy = (e.hi != 0) ? 1 : 0; e.lat = W;
            end
            default: e.out = y;
        endcase
        e.z = (o == 11) ? ((s == 0) ? 1 : 0) : ((e.out == 0) ? 1 : 0);
        e.n = (o == 11) ? (e.hi >> 7) & 1 : (e.out >> 7) & 1;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen, so the next call is back-to-back.
    task automatic run_op(int o, int x, int y, int ci, int glitch = -1);
        exp_t e;
        int cyc;
        bit seen;
        sb.push_back(model(o, x, y, ci));
        op = 4'(o); a = W'(x); b = W'(y); cin = ci[0]; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == glitch) begin
                start = 1'b1; op = 4'd0; a = 8'h11; b = 8'h22;
            end else if (cyc == glitch + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) seen = 1;
            else if (cyc == 1) chk("busy_run", busy, 1);
        end
        e = sb.pop_front();
        chk("done_seen", seen, 1);
        chk("latency", cyc, e.lat + 1);
        chk("busy_at_done", busy, 0);
        chk("out", out, e.out);
        chk("out_hi", out_hi, e.hi);
        chk("CY", CY, e.cy);
        chk("Z", Z, e.z);
        chk("N", N, e.n);
        chk("OV", OV, e.ov);
        last_out = e.out;
    endtask

    initial begin
        int sawdone;
        #12;
        chk("reset_outputs", {busy, done, out, out_hi, CY, Z, N, OV}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 8'hFF, 8'h01, 0);   // first edge after reset release
        run_op(1, 8'h02, 8'h05, 0);
        run_op(0, 8'h7F, 8'h01, 0);
        run_op(7, 8'h10, 8'h20, 1);
        run_op(11, 8'hFF, 8'hFF, 0);
        run_op(9, 8'h81, 3, 0);
        run_op(10, 8'h81, 0, 0);
        run_op(9, 8'h81, 20, 0);
        run_op(11, 8'h0D, 8'h0B, 0, 3);  // ADD start mid-MUL is ignored
        run_op(0, 8'h01, 8'h02, 0);     // accepted in MUL done cycle
        run_op(8, 8'h00, 8'h7F, 1);
        run_op(8, 8'hFF, 8'h7F, 1);
        run_op(10, 8'hF0, 4, 0);
        run_op(5, 8'h3C, 8'h00, 0);
        run_op(13, 8'h12, 8'hA5, 0);
        for (int i = 0; i < 16; i++)
            run_op($urandom_range(0, 15), $urandom_range(0, 255),
                   ($urandom_range(0, 1) != 0) ? $urandom_range(0, 10) : $urandom_range(0, 255),
                   $urandom_range(0, 1));
        run_op(2, 8'hF3, 8'h3F, 0);
        @(negedge clk);
        chk("done_pulse_one_cycle", done, 0);
        chk("out_hold", out, last_out);

        // Abort a MUL with reset partway through
        op = 4'd11; a = 8'd3; b = 8'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_clear", {busy, done, out, out_hi, CY, Z, N, OV}, 0);
        @(negedge clk);
        rst = 1'b0;
        sawdone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) sawdone++;
        end
        chk("no_done_after_rst", sawdone, 0);
        run_op(11, 8'd3, 8'd5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data path width (min 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port op  input  4  operation select.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B; shift count for shifts.
REQ-008 SHALL have port cin  input  1  carry/borrow in for ADC/SBC.
REQ-009 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port out  output  WIDTH  result (MUL: low half).
REQ-012 SHALL have port out_hi  output  WIDTH  MUL high half; 0 for other ops.
REQ-013 SHALL have ports CY, Z, N, OV  output  1 each  carry, zero, negative, signed overflow.

Function
REQ-014 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 PASS b, 7 ADC (a+b+cin), 8 SBC (a-b-cin), 9 SHL, 10 SHR (logical), 11 MUL (unsigned); 12-15 SHALL behave as PASS b.
REQ-015 States SHALL be IDLE and RUN; start=1 in IDLE latches a, b, op, cin at that edge.
REQ-016 Single-cycle ops (0-8, 12-15): result and flags registered at the start edge; done=1 for the following cycle; state stays IDLE.
REQ-017 Shift count c = min(b, WIDTH); c=0 SHALL complete as single-cycle with out=a, CY=0; otherwise RUN shifts one bit per cycle, done asserted after edge start+c.
REQ-018 MUL SHALL be shift-add, one partial product per cycle, done asserted after edge start+WIDTH; {out_hi,out} = a*b (2*WIDTH bits).
REQ-019 busy SHALL be 1 exactly while in RUN; busy=0 in the cycle done=1; back-to-back start accepted in that cycle.
REQ-020 start while busy=1 SHALL be ignored with no effect on the current operation.
REQ-021 CY: ADD/ADC carry-out of bit WIDTH-1; SUB/SBC borrow (1 when a < b+cin unsigned); shifts last bit shifted out; MUL 1 when out_hi != 0; logic/PASS/NOT 0.
REQ-022 OV SHALL be two's-complement overflow for ADD/ADC/SUB/SBC, 0 otherwise.
REQ-023 Z SHALL be (out==0) and N SHALL be out[WIDTH-1] (MUL: over full 2*WIDTH product, N = out_hi msb).
REQ-024 out, out_hi and flags SHALL update only at the completing edge and hold until the next completion.
REQ-025 Operand inputs changing during RUN SHALL not affect the result.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, busy=0, done=0, out=0, out_hi=0, CY=Z=N=OV=0, internal counters 0.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-028 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-029 Op-code constants and default WIDTH SHALL live in shared package alu_pkg.
REQ-030 The shift-add multiplier datapath SHALL be sub-module alu_mul (WIDTH parameter, start/done, product output); shifts and single-cycle ops remain in alu_mc.

Verification (WIDTH=8)
REQ-031 ADD a=0xFF b=0x01 -> next cycle done=1, out=0x00, CY=1, Z=1, OV=0; SUB a=0x02 b=0x05 -> out=0xFD, CY=1, N=1.
REQ-032 ADD a=0x7F b=0x01 -> out=0x80, OV=1, N=1; ADC a=0x10 b=0x20 cin=1 -> out=0x31, CY=0.
REQ-033 MUL a=0xFF b=0xFF -> busy 8 cycles, done after edge start+8, out=0x01, out_hi=0xFE, CY=1.
REQ-034 SHL a=0x81 b=3 -> done after edge start+3, out=0x08, CY=0; SHR a=0x81 b=0 -> single-cycle, out=0x81, CY=0; SHL b=20 -> 8 cycles, out=0x00, Z=1.
REQ-035 MUL started, start re-pulsed with op=ADD at cycle 3 -> ignored, MUL result unchanged; new start in done cycle accepted.
REQ-036 rst asserted at cycle 4 of MUL a=3 b=5 -> all outputs 0 immediately, no done after release.
